fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage plus IF/ID pipeline register of the pipelined RV32I core. It owns the PC, drives the synchronous instruction memory, and applies stalls and branch/jump redirects. It presents a registered instruction word, with its PC and a valid bit, to the decode stage, where the decoder and immediate generator consume `id_inst` directly.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP_INST`, default 32'h0000_0013 (`addi x0,x0,0`): word placed in `id_inst` for bubbles.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `imem_addr` output 32: byte address to the instruction BRAM. Combinational.
- `imem_rdata` input 32: BRAM read data. One-cycle read latency: address in cycle n, data in cycle n+1.
- `stall` input 1: from the hazard unit. Holds the PC and the IF/ID register.
- `redirect_valid` input 1: taken branch/jump from EX. Flushes IF/ID.
- `redirect_pc` input 32: redirect target. Bits [1:0] are forced to 0.
- `id_valid` output 1: `id_inst`/`id_pc` hold a real instruction.
- `id_inst` output 32: instruction word to decode/ImmGen.
- `id_pc` output 32: address of `id_inst`.
- `id_pc4` output 32: `id_pc + 4`, used by JAL/JALR link.

## Operation
- Internal state:
  - `pc_q`: address whose data is on `imem_rdata` this cycle.
  - `fv_q`: `imem_rdata` is a valid fetch.
- `imem_addr` selection, in priority order:
  - `redirect_valid` → `{redirect_pc[31:2],2'b00}`
  - else `stall` → `pc_q` (re-read the same word, so data is still present when the stall drops)
  - else → `pc_q + 4`
- Every rising edge, `pc_q <= imem_addr`.
- Redirect (highest priority, wins over simultaneous `stall`):
  - `id_valid<=0`, `id_inst<=NOP_INST`.
  - `id_pc`/`id_pc4` hold their old values.
  - `fv_q<=1`.
  - The wrong-path word currently on `imem_rdata` is discarded.
- Stall (no redirect):
  - All `id_*` registers hold.
  - `fv_q` holds.
- Advance (neither):
  - `id_valid<=fv_q`.
  - `id_inst<= fv_q ? imem_rdata : NOP_INST`.
  - `id_pc<=pc_q`, `id_pc4<=pc_q+4`.
  - `fv_q<=1`.
- Arithmetic is 32-bit modulo: `pc_q=32'hFFFF_FFFC` advances to 32'h0000_0000. No overflow flag.
- When `id_valid=0`, `id_inst` is always `NOP_INST`, so downstream decode needs no valid gating.

## Timing
- Reset values:
  - `pc_q=RESET_PC-4`, so the first `imem_addr` is `RESET_PC`.
  - `fv_q=0`.
  - `id_valid=0`, `id_inst=NOP_INST`, `id_pc=0`, `id_pc4=4`.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge. Any in-flight BRAM data is ignored because `fv_q=0`.
- First valid instruction:
  - Reset deasserts before edge 0. Edge 0 latches `RESET_PC`.
  - Edge 1 loads IF/ID, so `id_valid=1` from cycle 2 with `id_pc=RESET_PC`.
- Redirect penalty:
  - Redirect seen at edge k: bubble in ID during cycle k+1.
  - Target instruction is in ID from cycle k+2.
- Stall of N cycles holds `id_*` unchanged for exactly N cycles. The instruction after `id_pc` enters ID on the first non-stall edge. Nothing is lost or duplicated.
- Combinational paths:
  - `stall`/`redirect_*` → `imem_addr`.
  - No input → `id_*` combinational path; all `id_*` outputs are registered.

## Structure
- Shared defs header holds `NOP_INST` value (32'h0000_0013) and the default `RESET_PC`, next to the existing opcode defines.
- One natural sub-module, `if_id_reg`: the IF/ID register with hold/flush controls and the NOP insertion. The PC/address mux stays in `fetch_stage`.

## Test plan
- Reset then free-run, BRAM model word[i]=i:
  - `id_valid` rises in cycle 2.
  - `id_pc` sequence 0,4,8… with `id_inst` 0,1,2…
  - `id_pc4`=`id_pc`+4 throughout.
- Stall 3 cycles while `id_pc=8`:
  - `id_pc=8`, `id_inst=2` for 3 cycles.
  - Next edge gives `id_pc=12`, `id_inst=3`.
- Redirect to 32'h40 while `id_pc=8`:
  - Next cycle `id_valid=0`, `id_inst=32'h13`.
  - Following cycle `id_pc=32'h40`, `id_inst=16`.
- Redirect and stall asserted together, target 32'h100:
  - Redirect wins: bubble, then `id_pc=32'h100`.
  - `redirect_pc=32'h103` also lands at 32'h100.
- Redirect to 32'hFFFF_FFF8 with no stalls:
  - `id_pc` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Assert `rst` mid-stream, asynchronously between edges:
  - Outputs take reset values immediately.
  - After release, fetch restarts at `RESET_PC` with the same 2-cycle startup.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the RV32I fetch stage: bubble instruction, reset PC,
// address-select encoding and small PC helpers.
package fetch_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST_DEF = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_SYSTEM = 7'b1110011
  } opcode_e;

  typedef enum logic [1:0] {
    ADDR_SEQ      = 2'd0,
    ADDR_HOLD     = 2'd1,
    ADDR_REDIRECT = 2'd2
  } addr_sel_e;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory, hazard/redirect and IF/ID bundle of the fetch stage.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_valid;
  logic [XLEN-1:0] id_inst;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_pc4;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  stall,
    input  redirect_valid,
    input  redirect_pc,
    output id_valid,
    output id_inst,
    output id_pc,
    output id_pc4
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output stall,
    output redirect_valid,
    output redirect_pc,
    input  id_valid,
    input  id_inst,
    input  id_pc,
    input  id_pc4
  );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: hold on stall, flush to a NOP bubble on redirect,
// and substitute NOP whenever the fetched word is not valid.
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int unsigned       DATA_W   = XLEN,
  parameter logic [DATA_W-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              hold_i,
  input  logic              fv_i,
  input  logic [DATA_W-1:0] inst_i,
  input  logic [DATA_W-1:0] pc_i,
  output logic              id_valid_o,
  output logic [DATA_W-1:0] id_inst_o,
  output logic [DATA_W-1:0] id_pc_o,
  output logic [DATA_W-1:0] id_pc4_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] inst_q,  inst_d;
  logic [DATA_W-1:0] pc_q,    pc_d;
  logic [DATA_W-1:0] pc4_q,   pc4_d;

  // Flush keeps the PC fields: only the valid bit and the word are bubbled.
  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    if (flush_i) begin
      valid_d = 1'b0;
      inst_d  = NOP_INST;
    end else if (!hold_i) begin
      valid_d = fv_i;
      inst_d  = fv_i ? inst_i : NOP_INST;
      pc_d    = pc_i;
      pc4_d   = pc_i + DATA_W'(4);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      inst_q  <= NOP_INST;
      pc_q    <= '0;
      pc4_q   <= DATA_W'(4);
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
    end
  end

  assign id_valid_o = valid_q;
  assign id_inst_o  = inst_q;
  assign id_pc_o    = pc_q;
  assign id_pc4_o   = pc4_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: owns the PC, addresses the synchronous instruction
// BRAM and feeds the IF/ID register with stall and redirect handling.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  addr_sel_e       sel;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            fv_q, fv_d;

  logic            id_valid;
  logic [XLEN-1:0] id_inst;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_pc4;

  always_comb begin
    sel = ADDR_SEQ;
    if (bus.redirect_valid) begin
      sel = ADDR_REDIRECT;
    end else if (bus.stall) begin
      sel = ADDR_HOLD;
    end
  end

  // On stall the same word is re-read so it is still on imem_rdata when the
  // stall releases; pc_q always names the word currently on imem_rdata.
  always_comb begin
    pc_d = pc_plus4(pc_q);
    case (sel)
      ADDR_REDIRECT: pc_d = align_word(bus.redirect_pc);
      ADDR_HOLD:     pc_d = pc_q;
      default:       pc_d = pc_plus4(pc_q);
    endcase
  end

  assign bus.imem_addr = pc_d;
  assign fv_d          = (sel == ADDR_HOLD) ? fv_q : 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC - 32'd4;
      fv_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      fv_q <= fv_d;
    end
  end

  fetch_stage_if_id_reg #(
    .DATA_W   (XLEN),
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (sel == ADDR_REDIRECT),
    .hold_i     (sel == ADDR_HOLD),
    .fv_i       (fv_q),
    .inst_i     (bus.imem_rdata),
    .pc_i       (pc_q),
    .id_valid_o (id_valid),
    .id_inst_o  (id_inst),
    .id_pc_o    (id_pc),
    .id_pc4_o   (id_pc4)
  );

  assign bus.id_valid = id_valid;
  assign bus.id_inst  = id_inst;
  assign bus.id_pc    = id_pc;
  assign bus.id_pc4   = id_pc4;

endmodule
